// File: rtl/approx_add_pkg.sv
// Shared types and elaboration helpers for the pipelined approximate adder.
// The optional error-statistics shadow path is enabled by APPROX_ADD_PIPE_ERR_STATS_EN.
package approx_add_pkg;

    typedef struct packed {
        logic vld;
        logic mode;
        logic cy;
    } stage_ctrl_t;

    typedef struct packed {
        logic retire;
        logic differs;
    } err_evt_t;

    function automatic int chunk_w(input int w, input int stages);
        return w / stages;
    endfunction

    function automatic int k_chunk(input int k, input int cw);
        return k / cw;
    endfunction

    function automatic int k_local(input int k, input int cw);
        return k % cw;
    endfunction

    function automatic bit bit_is_approx(input int gi, input int k);
        return gi < k;
    endfunction

endpackage

// File: rtl/approx_add_pipe_if.sv
// Operand/result stream bundle for approx_add_pipe.
// Statistics signals exist only when APPROX_ADD_PIPE_ERR_STATS_EN is defined.
interface approx_add_pipe_if #(
    parameter int W     = 16,
    parameter int CNT_W = 16
);
    logic           IN_VALID;
    logic           IN_READY;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           MODE;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic [W:0]     O;
    logic           OUT_MODE;
`ifdef APPROX_ADD_PIPE_ERR_STATS_EN
    logic             CLR_STATS;
    logic [CNT_W-1:0] ERR_CNT;
    logic [W:0]       ERR_MAX;

    modport master (
        output IN_VALID, A, B, MODE, OUT_READY, CLR_STATS,
        input  IN_READY, OUT_VALID, O, OUT_MODE, ERR_CNT, ERR_MAX
    );
    modport slave (
        input  IN_VALID, A, B, MODE, OUT_READY, CLR_STATS,
        output IN_READY, OUT_VALID, O, OUT_MODE, ERR_CNT, ERR_MAX
    );
`else
    modport master (
        output IN_VALID, A, B, MODE, OUT_READY,
        input  IN_READY, OUT_VALID, O, OUT_MODE
    );
    modport slave (
        input  IN_VALID, A, B, MODE, OUT_READY,
        output IN_READY, OUT_VALID, O, OUT_MODE
    );
`endif
endinterface

// File: rtl/approx_add_chunk.sv
// Combinational chunk adder: ripple sum, except bits flagged in amask are XOR-only.
// The carry out of the highest flagged bit is the cut carry A[K-1]&B[K-1].
module approx_add_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    input  logic [CW-1:0] amask,
    output logic [CW-1:0] sum,
    output logic          cout
);
    logic [CW:0]   cy;
    logic [CW-1:0] mask_next;

    always_comb begin
        mask_next = amask >> 1;
        sum       = '0;
        cy        = '0;
        cy[0]     = cin;
        for (int i = 0; i < CW; i++) begin
            if (amask[i]) begin
                sum[i]  = a[i] ^ b[i];
                // only the top approximate bit (local position K-1) forwards a carry
                cy[i+1] = mask_next[i] ? 1'b0 : (a[i] & b[i]);
            end else begin
                sum[i]  = a[i] ^ b[i] ^ cy[i];
                cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
            end
        end
        cout = cy[CW];
    end

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined exact/approximate adder, one W/STAGES-bit chunk summed per stage.
// Define APPROX_ADD_PIPE_ERR_STATS_EN to add the exact shadow path and error statistics.
module approx_add_pipe
    import approx_add_pkg::*;
#(
    parameter int W      = 16,
    parameter int K      = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    approx_add_pipe_if.slave bus
);
    localparam int CW   = chunk_w(W, STAGES);
    localparam int LAST = STAGES - 1;

    logic advance;
    logic accept;
    logic init_q, init_d;

    stage_ctrl_t  ctrl_q [STAGES];
    stage_ctrl_t  ctrl_d [STAGES];
    logic [W-1:0] sum_q  [STAGES];
    logic [W-1:0] sum_d  [STAGES];
    logic [W-1:0] pa_q   [STAGES];
    logic [W-1:0] pa_d   [STAGES];
    logic [W-1:0] pb_q   [STAGES];
    logic [W-1:0] pb_d   [STAGES];

    stage_ctrl_t   src_ctrl [STAGES];
    logic [W-1:0]  src_sum  [STAGES];
    logic [W-1:0]  src_a    [STAGES];
    logic [W-1:0]  src_b    [STAGES];
    logic [CW-1:0] ch_sum   [STAGES];
    logic          ch_cout  [STAGES];

`ifdef APPROX_ADD_PIPE_ERR_STATS_EN
    logic [W-1:0]  ex_sum_q  [STAGES];
    logic [W-1:0]  ex_sum_d  [STAGES];
    logic          ex_cy_q   [STAGES];
    logic          ex_cy_d   [STAGES];
    logic [W-1:0]  src_ex_sum[STAGES];
    logic          src_ex_cy [STAGES];
    logic [CW-1:0] exch_sum  [STAGES];
    logic          exch_cout [STAGES];
`endif

    assign advance       = !ctrl_q[LAST].vld | bus.OUT_READY;
    assign accept        = bus.IN_VALID & init_q & advance;
    assign bus.IN_READY  = init_q & advance;
    assign bus.OUT_VALID = ctrl_q[LAST].vld;
    assign bus.OUT_MODE  = ctrl_q[LAST].mode;
    assign bus.O         = {ctrl_q[LAST].cy, sum_q[LAST]};

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [CW-1:0] amask;

        if (s == 0) begin : g_head
            assign src_ctrl[s] = '{vld: accept, mode: bus.MODE, cy: 1'b0};
            assign src_sum[s]  = '0;
            assign src_a[s]    = bus.A;
            assign src_b[s]    = bus.B;
        end else begin : g_body
            assign src_ctrl[s] = ctrl_q[s-1];
            assign src_sum[s]  = sum_q[s-1];
            assign src_a[s]    = pa_q[s-1];
            assign src_b[s]    = pb_q[s-1];
        end

        for (genvar i = 0; i < CW; i++) begin : g_mask
            assign amask[i] = src_ctrl[s].mode & bit_is_approx(s * CW + i, K);
        end

        approx_add_chunk #(.CW(CW)) u_chunk (
            .a     (src_a[s][s*CW +: CW]),
            .b     (src_b[s][s*CW +: CW]),
            .cin   (src_ctrl[s].cy),
            .amask (amask),
            .sum   (ch_sum[s]),
            .cout  (ch_cout[s])
        );

`ifdef APPROX_ADD_PIPE_ERR_STATS_EN
        if (s == 0) begin : g_ex_head
            assign src_ex_sum[s] = '0;
            assign src_ex_cy[s]  = 1'b0;
        end else begin : g_ex_body
            assign src_ex_sum[s] = ex_sum_q[s-1];
            assign src_ex_cy[s]  = ex_cy_q[s-1];
        end

        approx_add_chunk #(.CW(CW)) u_exact (
            .a     (src_a[s][s*CW +: CW]),
            .b     (src_b[s][s*CW +: CW]),
            .cin   (src_ex_cy[s]),
            .amask ('0),
            .sum   (exch_sum[s]),
            .cout  (exch_cout[s])
        );
`endif
    end

    always_comb begin
        init_d = 1'b1;
        for (int s = 0; s < STAGES; s++) begin
            ctrl_d[s] = ctrl_q[s];
            sum_d[s]  = sum_q[s];
            pa_d[s]   = pa_q[s];
            pb_d[s]   = pb_q[s];
            if (advance) begin
                ctrl_d[s].vld          = src_ctrl[s].vld;
                ctrl_d[s].mode         = src_ctrl[s].mode;
                ctrl_d[s].cy           = ch_cout[s];
                sum_d[s]               = src_sum[s];
                sum_d[s][s*CW +: CW]   = ch_sum[s];
                pa_d[s]                = src_a[s];
                pb_d[s]                = src_b[s];
            end
        end
    end

    // Control and result registers: reset clears everything visible on the output
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            init_q <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                ctrl_q[s] <= '0;
                sum_q[s]  <= '0;
            end
        end else begin
            init_q <= init_d;
            for (int s = 0; s < STAGES; s++) begin
                ctrl_q[s] <= ctrl_d[s];
                sum_q[s]  <= sum_d[s];
            end
        end
    end

    // Pending operand chunks carry no control meaning and need no reset
    always_ff @(posedge CLK) begin
        for (int s = 0; s < STAGES; s++) begin
            pa_q[s] <= pa_d[s];
            pb_q[s] <= pb_d[s];
        end
    end

    logic unused_pend;
    assign unused_pend = ^{pa_q[LAST], pb_q[LAST]};

`ifdef APPROX_ADD_PIPE_ERR_STATS_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [W:0]       err_max_q, err_max_d;
    logic [W:0]       exact_o;
    logic [W:0]       diff;
    err_evt_t         evt;

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            ex_sum_d[s] = ex_sum_q[s];
            ex_cy_d[s]  = ex_cy_q[s];
            if (advance) begin
                ex_sum_d[s]             = src_ex_sum[s];
                ex_sum_d[s][s*CW +: CW] = exch_sum[s];
                ex_cy_d[s]              = exch_cout[s];
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int s = 0; s < STAGES; s++) begin
            ex_sum_q[s] <= ex_sum_d[s];
            ex_cy_q[s]  <= ex_cy_d[s];
        end
    end

    // Approximation never over-estimates, so exact - O is the error magnitude
    always_comb begin
        exact_o     = {ex_cy_q[LAST], ex_sum_q[LAST]};
        diff        = exact_o - bus.O;
        evt.retire  = ctrl_q[LAST].vld & bus.OUT_READY;
        evt.differs = (exact_o != bus.O);
        err_cnt_d   = err_cnt_q;
        err_max_d   = err_max_q;
        if (bus.CLR_STATS) begin
            err_cnt_d = '0;
            err_max_d = '0;
        end else if (evt.retire && evt.differs) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (diff > err_max_q) err_max_d = diff;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_cnt_q <= '0;
            err_max_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            err_max_q <= err_max_d;
        end
    end

    assign bus.ERR_CNT = err_cnt_q;
    assign bus.ERR_MAX = err_max_q;
`endif

endmodule
